// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: valid/allowin handshake control for a five-stage in-order pipeline
// (DS -> ES -> PMS -> MS -> WS) with serialization of TLB/CACHE/MTC0 instructions
// and exception/ERET flush from writeback.
//
// Ports
//   clk            in   single clock, all state on the rising edge
//   reset          in   synchronous, active-high
//   ds_valid       in   decode holds a valid instruction
//   ds_stall       in   data-hazard stall from forwarding logic
//   ds_serial      in   decode instruction needs serialization
//   es/pms/ms_ready_go in  stage finishes this cycle
//   ws_ex, ws_eret in   exception / ERET committing in WS
//   ds_allowin     out  decode may accept a new instruction
//   ds_to_es_fire  out  DS -> ES transfer this cycle
//   *_valid        out  registered stage valid bits
//   *_we           out  stage payload register load enables
//   flush          out  combinational pipeline flush
//   refetch_req    out  one-cycle refetch pulse after serialization drains
//   ctrl_state     out  0 RUN, 1 DRAIN, 2 REFETCH
module pipeline_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       ds_valid,
  input  logic       ds_stall,
  input  logic       ds_serial,
  input  logic       es_ready_go,
  input  logic       pms_ready_go,
  input  logic       ms_ready_go,
  input  logic       ws_ex,
  input  logic       ws_eret,
  output logic       ds_allowin,
  output logic       ds_to_es_fire,
  output logic       es_valid,
  output logic       pms_valid,
  output logic       ms_valid,
  output logic       ws_valid,
  output logic       es_we,
  output logic       pms_we,
  output logic       ms_we,
  output logic       ws_we,
  output logic       flush,
  output logic       refetch_req,
  output logic [1:0] ctrl_state
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StDrain   = 2'd1,
    StRefetch = 2'd2
  } ctrl_state_e;

  ctrl_state_e state_q, state_d;

  logic es_valid_q,  es_valid_d;
  logic pms_valid_q, pms_valid_d;
  logic ms_valid_q,  ms_valid_d;
  logic ws_valid_q,  ws_valid_d;

  logic ws_allowin;
  logic ms_allowin;
  logic pms_allowin;
  logic es_allowin;
  logic ds_ready_go;
  logic fire;
  logic pipe_empty_next;

  // ---------------------------------------------------------------------------
  // Handshake network. Allowin ripples backwards from WS, so a single stage that
  // holds a valid instruction without ready_go stalls every earlier stage in the
  // same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    flush       = ws_valid_q & (ws_ex | ws_eret);
    ws_allowin  = 1'b1;
    ms_allowin  = ~ms_valid_q  | (ms_ready_go  & ws_allowin);
    pms_allowin = ~pms_valid_q | (pms_ready_go & ms_allowin);
    es_allowin  = ~es_valid_q  | (es_ready_go  & pms_allowin);

    // Decode only issues in RUN; DRAIN and REFETCH hold whatever sits in decode.
    ds_ready_go = ~ds_stall & (state_q == StRun);
    ds_allowin  = ~ds_valid | (ds_ready_go & es_allowin);
    fire        = ds_valid & ds_ready_go & es_allowin & ~flush;
  end

  // ---------------------------------------------------------------------------
  // Stage valid next-state and payload load enables.
  // ---------------------------------------------------------------------------
  always_comb begin
    es_valid_d  = es_valid_q;
    pms_valid_d = pms_valid_q;
    ms_valid_d  = ms_valid_q;
    ws_valid_d  = ws_valid_q;

    if (flush) begin
      es_valid_d  = 1'b0;
      pms_valid_d = 1'b0;
      ms_valid_d  = 1'b0;
      ws_valid_d  = 1'b0;
    end else begin
      if (es_allowin)  es_valid_d  = fire;
      if (pms_allowin) pms_valid_d = es_valid_q  & es_ready_go;
      if (ms_allowin)  ms_valid_d  = pms_valid_q & pms_ready_go;
      if (ws_allowin)  ws_valid_d  = ms_valid_q  & ms_ready_go;
    end
  end

  always_comb begin
    es_we  = fire;
    pms_we = pms_allowin & es_valid_q  & es_ready_go  & ~flush;
    ms_we  = ms_allowin  & pms_valid_q & pms_ready_go & ~flush;
    ws_we  = ws_allowin  & ms_valid_q  & ms_ready_go  & ~flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q  <= 1'b0;
      pms_valid_q <= 1'b0;
      ms_valid_q  <= 1'b0;
      ws_valid_q  <= 1'b0;
    end else begin
      es_valid_q  <= es_valid_d;
      pms_valid_q <= pms_valid_d;
      ms_valid_q  <= ms_valid_d;
      ws_valid_q  <= ws_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Serialization FSM: state register, next state, outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // DRAIN leaves at the edge where the last older instruction retires out of WS,
  // so the cycle after the pipe goes empty is already REFETCH.
  assign pipe_empty_next = ~(es_valid_d | pms_valid_d | ms_valid_d | ws_valid_d);

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun:     if (fire && ds_serial) state_d = StDrain;
        StDrain:   if (pipe_empty_next)   state_d = StRefetch;
        StRefetch: state_d = StRun;
        default:   state_d = StRun;
      endcase
    end
  end

  always_comb begin
    // The pipe is empty in REFETCH so flush cannot coincide; the mask keeps that
    // guarantee explicit.
    refetch_req = (state_q == StRefetch) & ~flush;
    ctrl_state  = state_q;
  end

  assign ds_to_es_fire = fire;
  assign es_valid      = es_valid_q;
  assign pms_valid     = pms_valid_q;
  assign ms_valid      = ms_valid_q;
  assign ws_valid      = ws_valid_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl. Each stimulus cycle pushes its
// hand-computed expected output vector into a scoreboard queue; a monitor on the
// falling edge pops and compares against the DUT outputs.
//
// Input vector  : {reset, ds_valid, ds_stall, ds_serial, es_rg, pms_rg, ms_rg, ws_ex, ws_eret}
// Expect vector : {ds_allowin, fire, v[es,pms,ms,ws], we[es,pms,ms,ws], flush, refetch, state[1:0]}
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ds_valid, ds_stall, ds_serial;
  logic       es_ready_go, pms_ready_go, ms_ready_go;
  logic       ws_ex, ws_eret;
  logic       ds_allowin, ds_to_es_fire;
  logic       es_valid, pms_valid, ms_valid, ws_valid;
  logic       es_we, pms_we, ms_we, ws_we;
  logic       flush, refetch_req;
  logic [1:0] ctrl_state;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .ds_valid     (ds_valid),
    .ds_stall     (ds_stall),
    .ds_serial    (ds_serial),
    .es_ready_go  (es_ready_go),
    .pms_ready_go (pms_ready_go),
    .ms_ready_go  (ms_ready_go),
    .ws_ex        (ws_ex),
    .ws_eret      (ws_eret),
    .ds_allowin   (ds_allowin),
    .ds_to_es_fire(ds_to_es_fire),
    .es_valid     (es_valid),
    .pms_valid    (pms_valid),
    .ms_valid     (ms_valid),
    .ws_valid     (ws_valid),
    .es_we        (es_we),
    .pms_we       (pms_we),
    .ms_we        (ms_we),
    .ws_we        (ws_we),
    .flush        (flush),
    .refetch_req  (refetch_req),
    .ctrl_state   (ctrl_state)
  );

  typedef struct {
    int          idx;
    logic [13:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  vec_idx  = 0;

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t         e;
      logic [13:0] act;
      e   = sb.pop_front();
      act = {ds_allowin, ds_to_es_fire, es_valid, pms_valid, ms_valid, ws_valid,
             es_we, pms_we, ms_we, ws_we, flush, refetch_req, ctrl_state};
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL vec%0d: outputs %b required %b", e.idx, act, e.exp);
      end
    end
  end

  task automatic step(input logic [8:0] in, input logic [13:0] exp);
    sb_t e;
    @(posedge clk);
    #1;
    {reset, ds_valid, ds_stall, ds_serial, es_ready_go, pms_ready_go, ms_ready_go,
     ws_ex, ws_eret} = in;
    e.idx = vec_idx;
    e.exp = exp;
    sb.push_back(e);
    vec_idx++;
  endtask

  // Fill an empty pipe with four back-to-back instructions (pipe full after).
  task automatic fill4();
    step(9'b0_100_111_00, 14'b11_0000_1000_00_00);
    step(9'b0_100_111_00, 14'b11_1000_1100_00_00);
    step(9'b0_100_111_00, 14'b11_1100_1110_00_00);
    step(9'b0_100_111_00, 14'b11_1110_1111_00_00);
  endtask

  initial begin
    {reset, ds_valid, ds_stall, ds_serial, es_ready_go, pms_ready_go, ms_ready_go,
     ws_ex, ws_eret} = 9'b1_000_111_00;

    // Reset state.
    step(9'b1_000_111_00, 14'b10_0000_0000_00_00);
    step(9'b1_000_111_00, 14'b10_0000_0000_00_00);
    step(9'b0_000_111_00, 14'b10_0000_0000_00_00);

    // Stream: six fires, WS valid four cycles after the first, then drain.
    fill4();
    step(9'b0_100_111_00, 14'b11_1111_1111_00_00);
    step(9'b0_100_111_00, 14'b11_1111_1111_00_00);
    step(9'b0_000_111_00, 14'b10_1111_0111_00_00);
    step(9'b0_000_111_00, 14'b10_0111_0011_00_00);
    step(9'b0_000_111_00, 14'b10_0011_0001_00_00);
    step(9'b0_000_111_00, 14'b10_0001_0000_00_00);

    // Stall for two cycles, then a single fire.
    step(9'b0_110_111_00, 14'b00_0000_0000_00_00);
    step(9'b0_110_111_00, 14'b00_0000_0000_00_00);
    step(9'b0_100_111_00, 14'b11_0000_1000_00_00);
    step(9'b0_000_111_00, 14'b10_1000_0100_00_00);
    step(9'b0_000_111_00, 14'b10_0100_0010_00_00);
    step(9'b0_000_111_00, 14'b10_0010_0001_00_00);
    step(9'b0_000_111_00, 14'b10_0001_0000_00_00);

    // Back-pressure: MS not ready for three cycles with a full pipe.
    fill4();
    step(9'b0_100_110_00, 14'b00_1111_0000_00_00);
    step(9'b0_100_110_00, 14'b00_1110_0000_00_00);
    step(9'b0_100_110_00, 14'b00_1110_0000_00_00);
    step(9'b0_000_111_00, 14'b10_1110_0111_00_00);
    step(9'b0_000_111_00, 14'b10_0111_0011_00_00);
    step(9'b0_000_111_00, 14'b10_0011_0001_00_00);
    step(9'b0_000_111_00, 14'b10_0001_0000_00_00);

    // Serialization into an empty pipe; decode keeps offering an instruction.
    step(9'b0_101_111_00, 14'b11_0000_1000_00_00);
    step(9'b0_100_111_00, 14'b00_1000_0100_00_01);
    step(9'b0_100_111_00, 14'b00_0100_0010_00_01);
    step(9'b0_100_111_00, 14'b00_0010_0001_00_01);
    step(9'b0_100_111_00, 14'b00_0001_0000_00_01);
    step(9'b0_100_111_00, 14'b00_0000_0000_01_10);
    step(9'b0_000_111_00, 14'b10_0000_0000_00_00);

    // Exception flush while decode would fire; then ERET with WS empty does nothing.
    fill4();
    step(9'b0_100_111_10, 14'b10_1111_0000_10_00);
    step(9'b0_000_111_01, 14'b10_0000_0000_00_00);

    // Flush on the second DRAIN cycle: back to RUN, no refetch.
    step(9'b0_100_111_00, 14'b11_0000_1000_00_00);
    step(9'b0_100_111_00, 14'b11_1000_1100_00_00);
    step(9'b0_101_111_00, 14'b11_1100_1110_00_00);
    step(9'b0_000_111_00, 14'b10_1110_0111_00_01);
    step(9'b0_000_111_10, 14'b10_0111_0000_10_01);
    step(9'b0_000_111_00, 14'b10_0000_0000_00_00);
    step(9'b0_000_111_00, 14'b10_0000_0000_00_00);
    step(9'b0_000_111_00, 14'b10_0000_0000_00_00);

    // Reset in the middle of DRAIN: serialization dropped, no refetch later.
    step(9'b0_101_111_00, 14'b11_0000_1000_00_00);
    step(9'b0_000_111_00, 14'b10_1000_0100_00_01);
    step(9'b1_000_111_00, 14'b10_0100_0010_00_01);
    step(9'b0_000_111_00, 14'b10_0000_0000_00_00);
    step(9'b0_000_111_00, 14'b10_0000_0000_00_00);
    step(9'b0_000_111_00, 14'b10_0000_0000_00_00);
    step(9'b0_000_111_00, 14'b10_0000_0000_00_00);

    // Let the monitor consume the remaining entries, with a bound.
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
